// File: rtl/hyperbus_master_ctrl.sv
// Host-side HyperBus master: turns single 32-bit read/write requests into
// CA, latency, data and recovery bus phases (one byte per clk, SDR model).
module hyperbus_master_ctrl #(
    parameter int LATENCY    = 6,
    parameter int RD_TIMEOUT = 64,
    parameter int T_RWR      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        cs_n,
    output logic        hb_ck_en,
    output logic [7:0]  dq_out,
    output logic        dq_oe,
    input  logic [7:0]  dq_in,
    output logic        rwds_out,
    output logic        rwds_oe,
    input  logic        rwds_in
);

    localparam int MAX_A   = (2 * LATENCY > RD_TIMEOUT) ? 2 * LATENCY : RD_TIMEOUT;
    localparam int MAX_B   = (T_RWR > 6) ? T_RWR : 6;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CA,
        S_LAT,
        S_WDATA,
        S_RDATA,
        S_RECOV
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               write_q, write_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               lat2x_q, lat2x_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic [23:0]        shift_q, shift_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               init_q;

    logic [47:0]        ca_word;
    logic [7:0]         ca_byte;
    logic [7:0]         wr_byte;
    logic               lat_last;

    assign ca_word  = {~write_q, 1'b0, 1'b1, addr_q[31:3], 13'b0, addr_q[2:0]};
    assign lat_last = (cnt_q == (lat2x_q ? CNT_W'(2 * LATENCY - 1) : CNT_W'(LATENCY - 1)));

    always_comb begin
        case (cnt_q[2:0])
            3'd0:    ca_byte = ca_word[47:40];
            3'd1:    ca_byte = ca_word[39:32];
            3'd2:    ca_byte = ca_word[31:24];
            3'd3:    ca_byte = ca_word[23:16];
            3'd4:    ca_byte = ca_word[15:8];
            3'd5:    ca_byte = ca_word[7:0];
            default: ca_byte = 8'h00;
        endcase
        case (cnt_q[1:0])
            2'd0:    wr_byte = wdata_q[31:24];
            2'd1:    wr_byte = wdata_q[23:16];
            2'd2:    wr_byte = wdata_q[15:8];
            default: wr_byte = wdata_q[7:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            lat2x_q     <= 1'b0;
            byte_cnt_q  <= '0;
            shift_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            init_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            lat2x_q     <= lat2x_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            init_q      <= 1'b1;
        end
    end

    always_comb begin
        // NOTE: every output and next-state gets a default first, so no path infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        lat2x_d     = lat2x_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        req_ready   = 1'b0;
        cs_n        = 1'b1;
        dq_oe       = 1'b0;
        dq_out      = 8'h00;
        rwds_oe     = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = init_q;
                if (req_valid && init_q) begin
                    write_d    = req_write;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    cnt_d      = '0;
                    byte_cnt_d = '0;
                    shift_d    = '0;
                    state_d    = S_CA;
                end
            end
            S_CA: begin
                cs_n   = 1'b0;
                dq_oe  = 1'b1;
                dq_out = ca_byte;
                // The slave flags doubled latency on rwds during the first CA byte.
                if (cnt_q == '0) lat2x_d = rwds_in;
                if (cnt_q == CNT_W'(5)) begin
                    cnt_d   = '0;
                    state_d = S_LAT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LAT: begin
                cs_n    = 1'b0;
                rwds_oe = write_q && lat_last;
                if (lat_last) begin
                    cnt_d   = '0;
                    state_d = write_q ? S_WDATA : S_RDATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WDATA: begin
                cs_n    = 1'b0;
                dq_oe   = 1'b1;
                rwds_oe = 1'b1;
                dq_out  = wr_byte;
                if (cnt_q == CNT_W'(3)) begin
                    cnt_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = S_RECOV;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RDATA: begin
                cs_n = 1'b0;
                if (rwds_in) begin
                    shift_d    = {shift_q[15:0], dq_in};
                    byte_cnt_d = byte_cnt_q + 1'b1;
                end
                // A fourth byte arriving on the timeout cycle still completes the read.
                if (rwds_in && byte_cnt_q == 2'd3) begin
                    cnt_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = {shift_q, dq_in};
                    state_d     = S_RECOV;
                end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
                    cnt_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = S_RECOV;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RECOV: begin
                if (cnt_q == CNT_W'(T_RWR - 1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign hb_ck_en  = ~cs_n;
    assign rwds_out  = 1'b0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_hyperbus_master_ctrl.sv
// Directed, table-driven bench for hyperbus_master_ctrl with a small
// cycle-accurate slave driver; inputs change on negedge, outputs sampled there.
module tb_hyperbus_master_ctrl;

    localparam int LATENCY    = 6;
    localparam int RD_TIMEOUT = 64;
    localparam int T_RWR      = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        cs_n;
    logic        hb_ck_en;
    logic [7:0]  dq_out;
    logic        dq_oe;
    logic [7:0]  dq_in;
    logic        rwds_out;
    logic        rwds_oe;
    logic        rwds_in;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        lat2x;
        logic [63:0] pat;
        logic [31:0] rbytes;
        logic [47:0] ca;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t tbl[8];

    hyperbus_master_ctrl #(
        .LATENCY   (LATENCY),
        .RD_TIMEOUT(RD_TIMEOUT),
        .T_RWR     (T_RWR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_err  (rsp_err),
        .rsp_rdata(rsp_rdata),
        .cs_n     (cs_n),
        .hb_ck_en (hb_ck_en),
        .dq_out   (dq_out),
        .dq_oe    (dq_oe),
        .dq_in    (dq_in),
        .rwds_out (rwds_out),
        .rwds_oe  (rwds_oe),
        .rwds_in  (rwds_in)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one request; rst_at >= 0 pulls reset during that WDATA byte instead of finishing.
    task automatic run_txn(input vec_t v, input int idx, input int rst_at);
        string tag;
        int    lx;
        int    b;
        int    i;
        int    waited;
        tag    = $sformatf("v%0d", idx);
        lx     = v.lat2x ? 2 * LATENCY : LATENCY;
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_ready"}, req_ready, 1);
        if (!req_ready) return;

        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        @(negedge clk);
        req_valid = 1'b0;

        for (int k = 0; k < 6; k++) begin
            if (k == 0) begin
                check({tag, "_ca_csn"}, cs_n, 0);
                check({tag, "_ca_ck_en"}, hb_ck_en, 1);
            end
            check($sformatf("%s_ca_oe%0d", tag, k), dq_oe, 1);
            check($sformatf("%s_ca_byte%0d", tag, k), dq_out, v.ca[47-8*k -: 8]);
            rwds_in = v.lat2x;
            dq_in   = 8'h00;
            @(negedge clk);
        end

        rwds_in = 1'b1;
        dq_in   = 8'hEE;
        for (int j = 0; j < lx; j++) begin
            check($sformatf("%s_lat_oe%0d", tag, j), dq_oe, 0);
            check($sformatf("%s_lat_rwds_oe%0d", tag, j), rwds_oe, (v.wr && j == lx - 1) ? 1 : 0);
            @(negedge clk);
        end

        if (v.wr) begin
            rwds_in = 1'b0;
            dq_in   = 8'h00;
            for (int k = 0; k < 4; k++) begin
                if (k == rst_at) begin
                    rst_n = 1'b0;
                    #1;
                    check({tag, "_rst_csn"}, cs_n, 1);
                    check({tag, "_rst_dq_oe"}, dq_oe, 0);
                    check({tag, "_rst_rwds_oe"}, rwds_oe, 0);
                    check({tag, "_rst_ck_en"}, hb_ck_en, 0);
                    check({tag, "_rst_dq_out"}, dq_out, 0);
                    repeat (2) @(negedge clk);
                    rst_n = 1'b1;
                    return;
                end
                check($sformatf("%s_wr_byte%0d", tag, k), dq_out, v.wdata[31-8*k -: 8]);
                check($sformatf("%s_wr_oe%0d", tag, k), dq_oe, 1);
                check($sformatf("%s_wr_rwds_oe%0d", tag, k), rwds_oe, 1);
                check($sformatf("%s_wr_rwds_out%0d", tag, k), rwds_out, 0);
                @(negedge clk);
            end
        end else begin
            b = 0;
            i = 0;
            while (i < RD_TIMEOUT && b < 4) begin
                check($sformatf("%s_rd_busy%0d", tag, i), cs_n, 0);
                rwds_in = v.pat[i];
                dq_in   = v.pat[i] ? v.rbytes[31-8*b -: 8] : 8'hEE;
                if (v.pat[i]) b++;
                i++;
                @(negedge clk);
            end
        end
        rwds_in = 1'b0;
        dq_in   = 8'h00;

        check({tag, "_rsp_valid"}, rsp_valid, 1);
        check({tag, "_rsp_err"}, rsp_err, v.exp_err);
        if (!v.wr) check({tag, "_rsp_rdata"}, rsp_rdata, v.exp_rdata);
        check({tag, "_rsp_csn"}, cs_n, 1);
        check({tag, "_rsp_oe"}, dq_oe | rwds_oe, 0);
        check({tag, "_rsp_ready"}, req_ready, 0);
        @(negedge clk);
        check({tag, "_rsp_pulse"}, rsp_valid, 0);
        check({tag, "_recov_ready"}, req_ready, 0);
        check({tag, "_recov_csn"}, cs_n, 1);
        @(negedge clk);
        check({tag, "_idle_ready"}, req_ready, 1);
    endtask

    initial begin
        tbl[0] = '{wr:1'b1, addr:32'h0000_1234, wdata:32'hDEAD_BEEF, lat2x:1'b0, pat:64'h0,
                   rbytes:32'h0, ca:48'h2000_0246_0004, exp_rdata:32'h0, exp_err:1'b0};
        tbl[1] = '{wr:1'b0, addr:32'h0000_0010, wdata:32'h0, lat2x:1'b0, pat:64'hF,
                   rbytes:32'h1122_3344, ca:48'hA000_0002_0000, exp_rdata:32'h1122_3344, exp_err:1'b0};
        tbl[2] = '{wr:1'b0, addr:32'h0000_0010, wdata:32'h0, lat2x:1'b1, pat:64'hF,
                   rbytes:32'h5566_7788, ca:48'hA000_0002_0000, exp_rdata:32'h5566_7788, exp_err:1'b0};
        tbl[3] = '{wr:1'b0, addr:32'h0ABC_DEF7, wdata:32'h0, lat2x:1'b0, pat:64'h35,
                   rbytes:32'h9ABC_DEF0, ca:48'hA157_9BDE_0007, exp_rdata:32'h9ABC_DEF0, exp_err:1'b0};
        tbl[4] = '{wr:1'b1, addr:32'hFFFF_FFF8, wdata:32'h0123_4567, lat2x:1'b1, pat:64'h0,
                   rbytes:32'h0, ca:48'h3FFF_FFFF_0000, exp_rdata:32'h0, exp_err:1'b0};
        tbl[5] = '{wr:1'b0, addr:32'h0000_0000, wdata:32'h0, lat2x:1'b0, pat:64'h0,
                   rbytes:32'h0, ca:48'hA000_0000_0000, exp_rdata:32'h0, exp_err:1'b1};
        tbl[6] = '{wr:1'b0, addr:32'h0000_0003, wdata:32'h0, lat2x:1'b0, pat:64'hF000_0000_0000_0000,
                   rbytes:32'hC1C2_C3C4, ca:48'hA000_0000_0003, exp_rdata:32'hC1C2_C3C4, exp_err:1'b0};
        tbl[7] = '{wr:1'b0, addr:32'h0000_0005, wdata:32'h0, lat2x:1'b0, pat:64'hE000_0000_0000_0000,
                   rbytes:32'hD1D2_D3D4, ca:48'hA000_0000_0005, exp_rdata:32'h0, exp_err:1'b1};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        dq_in     = '0;
        rwds_in   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_csn", cs_n, 1);
        check("reset_ck_en", hb_ck_en, 0);
        check("reset_dq_oe", dq_oe, 0);
        check("reset_rwds_oe", rwds_oe, 0);
        check("reset_rwds_out", rwds_out, 0);
        check("reset_dq_out", dq_out, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_err", rsp_err, 0);
        check("reset_rsp_rdata", rsp_rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_ready", req_ready, 1);

        for (int n = 0; n < 8; n++) run_txn(tbl[n], n, -1);

        run_txn(tbl[0], 100, 2);
        @(negedge clk);
        check("post_reset_ready", req_ready, 1);
        check("post_reset_rsp_valid", rsp_valid, 0);
        run_txn(tbl[0], 101, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hyperbus_master_ctrl.md
Name: hyperbus_master_ctrl

Overview:
- Host-side HyperBus controller that sits directly upstream of hyperbusslave.
- Accepts single 32-bit read/write requests on a valid/ready host port.
- Drives the bus through chip-select, command-address (CA), latency, data and recovery phases, then returns one response per request.
- Bus model is simplified to one byte per `clk` cycle (SDR), matching the slave testbench.

Parameters:
- LATENCY, 6: initial-access latency in clk cycles (single latency).
- RD_TIMEOUT, 64: maximum read data-phase cycles before the read is aborted.
- T_RWR, 2: minimum cs_n-high recovery cycles between transactions.

Ports:
- clk  input  1  system clock; also the bus byte clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  host request valid.
- req_ready  output  1  controller idle; request accepted when req_valid & req_ready.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  32  16-bit-word address.
- req_wdata  input  32  write data.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_err  output  1  read timeout flag, qualified by rsp_valid.
- rsp_rdata  output  32  read data, qualified by rsp_valid.
- cs_n  output  1  bus chip select, active low.
- hb_ck_en  output  1  bus clock gate; high exactly while cs_n = 0.
- dq_out  output  8  bus data out.
- dq_oe  output  1  dq output enable.
- dq_in  input  8  bus data in.
- rwds_out  output  1  write data mask; always 0 (no masking).
- rwds_oe  output  1  rwds output enable.
- rwds_in  input  1  rwds from the slave.

Behaviour:
- Reset (async, any state):
  - cs_n = 1; hb_ck_en, dq_oe, rwds_oe, rwds_out, rsp_valid, rsp_err = 0.
  - dq_out = 0, rsp_rdata = 0, state = IDLE.
  - req_ready = 1 from the first clk after deassertion.
- States: IDLE, CA, LAT, WDATA, RDATA, RECOV.
- IDLE:
  - req_ready = 1; it is 0 in every other state.
  - On acceptance at cycle T: latch write flag, address and wdata; go to CA.
- CA (cycles T+1..T+6):
  - cs_n = 0, dq_oe = 1.
  - CA word: CA[47] = ~req_write, CA[46] = 0 (memory space), CA[45] = 1 (linear burst), CA[44:16] = addr[31:3], CA[15:3] = 0, CA[2:0] = addr[2:0].
  - Bytes are driven MSB first: CA[47:40] on T+1 through CA[7:0] on T+6.
  - rwds_in sampled at T+1 selects latency: 1 gives Lx = 2*LATENCY, 0 gives Lx = LATENCY.
- LAT:
  - Lx cycles with dq_oe = 0, cs_n = 0.
  - Write: rwds_oe rises on the last LAT cycle.
- WDATA (4 cycles):
  - dq_oe = 1, rwds_oe = 1, rwds_out = 0.
  - Bytes wdata[31:24], [23:16], [15:8], [7:0], in that order.
  - Cycle after the last byte: cs_n = 1, oe signals = 0, rsp_valid = 1, rsp_err = 0; enter RECOV.
- RDATA:
  - dq_oe = 0.
  - Each cycle with rwds_in = 1 captures dq_in into the next byte slot, MSB first; cycles with rwds_in = 0 are ignored.
  - Cycle after the 4th capture: cs_n = 1, rsp_valid = 1, rsp_rdata = assembled word, rsp_err = 0.
  - Timeout counter starts at 0 in the first RDATA cycle. If it reaches RD_TIMEOUT with fewer than 4 bytes captured: cs_n = 1, rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
  - A 4th capture on the timeout cycle wins; the read completes normally.
- RECOV:
  - cs_n stays 1 for T_RWR cycles, then IDLE.
  - Write with Lx = 6: acceptance T, last byte T+16, rsp T+17, req_ready = 1 at T+19.
- rsp_valid is exactly one cycle and is never asserted while req_ready = 1.
- The host holds no other data; a new request is only possible after RECOV.

Test Plan:
- Write addr 0x0000_1234, wdata 0xDEADBEEF, rwds_in = 0 -> CA bytes 0x20,0x00,0x02,0x46,0x00,0x04; 6 latency cycles; dq DE,AD,BE,EF; rsp_valid at T+17; req_ready at T+19.
- Read addr 0x10, slave returns 11,22,33,44 with rwds_in = 1 -> CA byte0 = 0xA0; rsp_rdata = 0x11223344, rsp_err = 0.
- Read with rwds_in = 1 during CA byte 0 -> 12 latency cycles before RDATA.
- Read with rwds_in gapped (1,0,1,0,1,1) -> gaps skipped, correct 4-byte word assembled.
- Read with rwds_in stuck at 0 -> abort after 64 RDATA cycles, rsp_err = 1, rsp_rdata = 0, cs_n = 1.
- rst_n low mid-WDATA -> cs_n = 1 and dq_oe = 0 the same cycle; after release, req_ready = 1 and the next write is correct.
